countdown_counter: RTL and testbench
====================================

// Module: countdown_counter
// PURPOSE
//  Loadable down-counter with start/busy/done handshake.
//  Mirror of the team's up-counter: it loads a value and decrements it to zero,
//  then reports completion. Used by CA2 controllers as a loop/iteration timer.
//  Decrements by SUB_VAL on each enabled cycle and saturates at zero.
// PARAMETERS
//  SUB_VAL        1   decrement step; legal range 1 .. 2**COUNTER_WIDTH-1
//  COUNTER_WIDTH  3   width of count and load_val
// PORTS
//  clk       in   1    single clock; rising edge
//  reset     in   1    asynchronous reset, active-low (0 = reset)
//  load      in   1    1-cycle strobe: count <= load_val
//  load_val  in   W    value captured on load
//  start     in   1    1-cycle strobe: begin counting down
//  cnt       in   1    decrement enable, sampled only while busy
//  count     out  W    current counter value (registered)
//  busy      out  1    high while in RUN
//  done      out  1    registered 1-cycle pulse at terminal count
// BEHAVIOUR
//  - Reset (reset==0, async assert, sync release): state=IDLE, count=0, busy=0, done=0.
//  - FSM states: IDLE, RUN, DONE. busy = (state==RUN). done is its own register.
//  - IDLE:
//    - load=1: count<=load_val; start is ignored in that same cycle.
//    - start=1 with count!=0: -> RUN; busy rises 1 cycle after start.
//    - start=1 with count==0: -> DONE; done pulses the next cycle.
//  - RUN, cnt=1: next = (count<=SUB_VAL) ? 0 : count-SUB_VAL.
//    - Subtraction is W bits wide and never wraps below zero.
//    - If next==0: count<=0, done<=1, state -> DONE.
//  - RUN, cnt=0: count holds; no other change.
//  - DONE: lasts exactly 1 cycle; done=1, busy=0; -> IDLE. count stays 0.
//  - load during RUN or DONE: abort.
//    - count<=load_val, state -> IDLE, done forced 0, no done pulse.
//  - start during RUN or DONE: ignored.
//  - Priority within a cycle: load > start > cnt.
//  - Reset mid-operation: immediate return to the reset values; any pending done is lost.
//  - Latency: with cnt held high, done is seen ceil(L/SUB_VAL) cycles after busy rises (L = loaded value).
// CONFIGURATION
//  Macro COUNTDOWN_AUTO_RELOAD_EN.
//  Defined:
//    - A reload register captures load_val on every load; it resets to 0.
//    - At terminal count in RUN: count<=reload register, state stays RUN, done pulses 1 cycle.
//    - The DONE state is unreachable from RUN; start with count==0 still -> DONE.
//    - If the reload value is 0: -> DONE, then IDLE (this prevents a stuck RUN).
//  Undefined: behaviour exactly as above; no reload register is instantiated.
// STRUCTURE
//  Package countdown_pkg:
//    - state typedef enum {IDLE, RUN, DONE}, 2-bit encoding.
//    - localparam for the zero/terminal compare helper.
//  One sub-module, sat_sub: combinational saturating subtractor (W-bit a - b, floor 0).
//  FSM, count register, done register and the optional reload register stay in the top level.
// TESTING
//  1 Defaults; load 5, start, cnt=1 held -> busy next cycle; count 5,4,3,2,1,0;
//    done=1 one cycle with count==0, then IDLE.
//  2 SUB_VAL=2; load 5, start, cnt=1 -> count 5,3,1,0; no wrap to 7; done once.
//  3 load 4, start, cnt toggling 1,0,1,0 -> count changes only on cnt=1 cycles;
//    done after 4 enabled cycles.
//  4 load 6, start, after 2 decrements pull reset low asynchronously -> count=0,
//    busy=0, done=0 immediately; no done after release.
//  5 load 7, start, after 1 decrement load 3 -> IDLE, count=3, no done pulse;
//    start with count==0 -> done next cycle.
//  6 COUNTDOWN_AUTO_RELOAD_EN, load 2, start, cnt=1 -> count 2,1,2,1,... with
//    done each time count hits zero; busy stays 1.

Source files
------------

// File: rtl/countdown_pkg.sv
// countdown_pkg: shared state encoding and terminal-count constant for countdown_counter
package countdown_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam int TERM_COUNT = 0;
endpackage

// File: rtl/sat_sub.sv
// sat_sub: combinational W-bit saturating subtractor, floor at zero
module sat_sub #(
  parameter int W = 3
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] y
);
  assign y = (a <= b) ? '0 : a - b;
endmodule

// File: rtl/countdown_counter.sv
// countdown_counter: loadable down-counter with start/busy/done handshake
// COUNTDOWN_AUTO_RELOAD_EN: reload the last loaded value at terminal count and keep running
module countdown_counter #(
  parameter int SUB_VAL       = 1,
  parameter int COUNTER_WIDTH = 3
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     load,
  input  logic [COUNTER_WIDTH-1:0] load_val,
  input  logic                     start,
  input  logic                     cnt,
  output logic [COUNTER_WIDTH-1:0] count,
  output logic                     busy,
  output logic                     done
);
  import countdown_pkg::*;
  localparam int W = COUNTER_WIDTH;
  localparam logic [W-1:0] STEP = W'(SUB_VAL);
  localparam logic [W-1:0] TERM = W'(TERM_COUNT);
  state_t state, state_d;
  logic [W-1:0] count_d, diff;
  logic done_d;
  sat_sub #(.W(W)) u_sub (.a(count), .b(STEP), .y(diff));
`ifdef COUNTDOWN_AUTO_RELOAD_EN
  logic [W-1:0] reload;
  always_ff @(posedge clk or negedge reset)
    if (!reset) reload <= '0;
    else if (load) reload <= load_val;
`endif
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= IDLE;
      count <= '0;
      done  <= 1'b0;
    end else begin
      state <= state_d;
      count <= count_d;
      done  <= done_d;
    end
  // priority load > start > cnt; done is high only on entry to terminal count
  always_comb begin
    state_d = state;
    count_d = count;
    done_d  = 1'b0;
    if (load) begin
      state_d = IDLE;
      count_d = load_val;
    end else if (state == IDLE && start) begin
      state_d = (count == TERM) ? DONE : RUN;
      done_d  = (count == TERM);
    end else if (state == RUN && cnt) begin
      count_d = diff;
      if (diff == TERM) begin
        done_d = 1'b1;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
        state_d = (reload == TERM) ? DONE : RUN;
        count_d = reload;
`else
        state_d = DONE;
`endif
      end
    end else if (state == DONE) begin
      state_d = IDLE;
    end
  end
  assign busy = (state == RUN);
endmodule

// File: tb/tb_countdown_counter.sv
// tb_countdown_counter: table-driven scoreboard bench for countdown_counter
module tb_countdown_counter;
  typedef struct {
    logic       sel;
    logic       ld;
    logic [2:0] lv;
    logic       st;
    logic       cn;
    logic [2:0] ec;
    logic       eb;
    logic       ed;
  } vec_t;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic load = 1'b0, start = 1'b0, cnt = 1'b0;
  logic [2:0] load_val = '0;
  logic [2:0] count1, count2;
  logic busy1, busy2, done1, done2;
  int checks = 0, failures = 0;
  vec_t tab[$];
  vec_t exp_q[$];
  always #5 clk = ~clk;
  countdown_counter #(.SUB_VAL(1), .COUNTER_WIDTH(3)) dut (
    .clk(clk), .reset(reset), .load(load), .load_val(load_val), .start(start), .cnt(cnt),
    .count(count1), .busy(busy1), .done(done1)
  );
  countdown_counter #(.SUB_VAL(2), .COUNTER_WIDTH(3)) dut2 (
    .clk(clk), .reset(reset), .load(load), .load_val(load_val), .start(start), .cnt(cnt),
    .count(count2), .busy(busy2), .done(done2)
  );
  function automatic vec_t mk(input logic sel, ld, input logic [2:0] lv, input logic st, cn,
                              input logic [2:0] ec, input logic eb, ed);
    vec_t v;
    v.sel = sel; v.ld = ld; v.lv = lv; v.st = st; v.cn = cn;
    v.ec = ec; v.eb = eb; v.ed = ed;
    return v;
  endfunction
  task automatic check(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", nm, act, exp);
    end
  endtask
  task automatic step(input vec_t v, input string nm);
    vec_t e;
    @(negedge clk);
    load = v.ld; load_val = v.lv; start = v.st; cnt = v.cn;
    exp_q.push_back(v);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check({nm, " count"}, e.sel ? count2 : count1, e.ec);
    check({nm, " busy"},  e.sel ? busy2  : busy1,  e.eb);
    check({nm, " done"},  e.sel ? done2  : done1,  e.ed);
  endtask
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0; load = 0; start = 0; cnt = 0;
    @(negedge clk);
    reset = 1'b1;
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end
  initial begin
    #12;
    check("reset count", count1, 0);
    check("reset busy", busy1, 0);
    check("reset done", done1, 0);
    do_reset();
`ifdef COUNTDOWN_AUTO_RELOAD_EN
    tab.push_back(mk(0, 1, 2, 0, 0, 2, 0, 0));
    tab.push_back(mk(0, 0, 0, 1, 1, 2, 1, 0));
    tab.push_back(mk(0, 0, 0, 0, 1, 1, 1, 0));
    tab.push_back(mk(0, 0, 0, 0, 1, 2, 1, 1));
    tab.push_back(mk(0, 0, 0, 0, 1, 1, 1, 0));
    tab.push_back(mk(0, 0, 0, 0, 1, 2, 1, 1));
    tab.push_back(mk(0, 0, 0, 0, 0, 2, 1, 0));
    tab.push_back(mk(0, 1, 0, 0, 1, 0, 0, 0));
    tab.push_back(mk(0, 0, 0, 1, 0, 0, 0, 1));
    tab.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0));
    foreach (tab[i]) step(tab[i], $sformatf("reload[%0d]", i));
`else
    tab.push_back(mk(0, 1, 5, 0, 0, 5, 0, 0));
    tab.push_back(mk(0, 0, 0, 1, 1, 5, 1, 0));
    tab.push_back(mk(0, 0, 0, 0, 1, 4, 1, 0));
    tab.push_back(mk(0, 0, 0, 0, 1, 3, 1, 0));
    tab.push_back(mk(0, 0, 0, 0, 1, 2, 1, 0));
    tab.push_back(mk(0, 0, 0, 0, 1, 1, 1, 0));
    tab.push_back(mk(0, 0, 0, 0, 1, 0, 0, 1));
    tab.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0));
    tab.push_back(mk(0, 1, 4, 0, 0, 4, 0, 0));
    tab.push_back(mk(0, 0, 0, 1, 0, 4, 1, 0));
    tab.push_back(mk(0, 0, 0, 0, 1, 3, 1, 0));
    tab.push_back(mk(0, 0, 0, 0, 0, 3, 1, 0));
    tab.push_back(mk(0, 0, 0, 0, 1, 2, 1, 0));
    tab.push_back(mk(0, 0, 0, 0, 0, 2, 1, 0));
    tab.push_back(mk(0, 0, 0, 0, 1, 1, 1, 0));
    tab.push_back(mk(0, 0, 0, 0, 0, 1, 1, 0));
    tab.push_back(mk(0, 0, 0, 0, 1, 0, 0, 1));
    tab.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0));
    tab.push_back(mk(0, 1, 7, 0, 0, 7, 0, 0));
    tab.push_back(mk(0, 0, 0, 1, 1, 7, 1, 0));
    tab.push_back(mk(0, 0, 0, 0, 1, 6, 1, 0));
    tab.push_back(mk(0, 1, 3, 0, 1, 3, 0, 0));
    tab.push_back(mk(0, 0, 0, 0, 1, 3, 0, 0));
    tab.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0));
    tab.push_back(mk(0, 0, 0, 1, 0, 0, 0, 1));
    tab.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0));
    tab.push_back(mk(0, 1, 2, 1, 0, 2, 0, 0));
    tab.push_back(mk(0, 0, 0, 1, 0, 2, 1, 0));
    tab.push_back(mk(0, 0, 0, 1, 0, 2, 1, 0));
    tab.push_back(mk(0, 0, 0, 0, 1, 1, 1, 0));
    tab.push_back(mk(0, 0, 0, 0, 1, 0, 0, 1));
    tab.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0));
    foreach (tab[i]) step(tab[i], $sformatf("vec[%0d]", i));
    step(mk(0, 1, 6, 0, 0, 6, 0, 0), "rst load");
    step(mk(0, 0, 0, 1, 1, 6, 1, 0), "rst start");
    step(mk(0, 0, 0, 0, 1, 5, 1, 0), "rst dec1");
    step(mk(0, 0, 0, 0, 1, 4, 1, 0), "rst dec2");
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check("async rst count", count1, 0);
    check("async rst busy", busy1, 0);
    check("async rst done", done1, 0);
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) step(mk(0, 0, 0, 0, 1, 0, 0, 0), $sformatf("post rst[%0d]", i));
    do_reset();
    step(mk(1, 1, 5, 0, 0, 5, 0, 0), "sub2 load");
    step(mk(1, 0, 0, 1, 1, 5, 1, 0), "sub2 start");
    step(mk(1, 0, 0, 0, 1, 3, 1, 0), "sub2 dec1");
    step(mk(1, 0, 0, 0, 1, 1, 1, 0), "sub2 dec2");
    step(mk(1, 0, 0, 0, 1, 0, 0, 1), "sub2 sat");
    step(mk(1, 0, 0, 0, 1, 0, 0, 0), "sub2 idle");
`endif
    check("scoreboard empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
